// File: rtl/sram_host_arbiter_pkg.sv
// Shared types and constants for the SRAM host arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_INSTR,
        OWNER_DATA
    } owner_e;

    localparam logic [3:0] BE_FULL = 4'hF;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] mask,
                                       input logic [31:0] base);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sram_host_arbiter_if.sv
// Host and SRAM port bundle for sram_host_arbiter; signal names match the original flat ports.
interface sram_host_arbiter_if;

    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        instr_err_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/sram_host_arbiter_pick.sv
// Combinational two-host winner select; prefer_data breaks ties toward the data host.
module sram_arb_pick (
    input  logic instr_req,
    input  logic data_req,
    input  logic prefer_data,
    output logic pick_instr,
    output logic pick_data
);

    always_comb begin
        pick_instr = instr_req && !(data_req && prefer_data);
        pick_data  = data_req && !pick_instr;
    end

endmodule

// File: rtl/sram_host_arbiter.sv
// Two-host to single-port SRAM arbiter with out-of-window error responses.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed instr priority with starvation guard.
module sram_host_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int unsigned MemSize     = 65536,
    parameter int unsigned StarveLimit = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    sram_host_arbiter_if.slave bus
);

    localparam logic [31:0] WinMask = ~(32'(MemSize) - 32'd1);

    logic   instr_req, data_req;
    logic   pick_instr, pick_data, prefer_data;
    logic   sel_in_win;
    owner_e owner_q, owner_d;
    logic   err_q, err_d;

    // Requests are masked during reset so no grant or SRAM access leaks out.
    assign instr_req = bus.instr_req_i & ~rst_i;
    assign data_req  = bus.data_req_i & ~rst_i;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e rr_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           rr_ptr_q <= OWNER_INSTR;
        else if (pick_instr) rr_ptr_q <= OWNER_DATA;
        else if (pick_data)  rr_ptr_q <= OWNER_INSTR;
    end

    assign prefer_data = (rr_ptr_q == OWNER_DATA);
`else
    localparam int unsigned CntW = ($clog2(StarveLimit + 1) > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

    logic [CntW-1:0] starve_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                         starve_cnt_q <= '0;
        else if (!data_req || pick_data)   starve_cnt_q <= '0;
        else if (starve_cnt_q != CntMax)   starve_cnt_q <= starve_cnt_q + 1'b1;
    end

    assign prefer_data = (starve_cnt_q >= CntMax);
`endif

    sram_arb_pick u_pick (
        .instr_req  (instr_req),
        .data_req   (data_req),
        .prefer_data(prefer_data),
        .pick_instr (pick_instr),
        .pick_data  (pick_data)
    );

    always_comb begin
        bus.instr_gnt_o = 1'b0;
        bus.data_gnt_o  = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        sel_in_win      = 1'b0;
        owner_d         = OWNER_NONE;
        err_d           = 1'b0;
        if (pick_instr) begin
            bus.instr_gnt_o = 1'b1;
            sel_in_win      = in_window(bus.instr_addr_i, WinMask, MemStart);
            owner_d         = OWNER_INSTR;
            if (sel_in_win) begin
                bus.mem_req_o  = 1'b1;
                bus.mem_be_o   = BE_FULL;
                bus.mem_addr_o = bus.instr_addr_i;
            end
        end else if (pick_data) begin
            bus.data_gnt_o = 1'b1;
            sel_in_win     = in_window(bus.data_addr_i, WinMask, MemStart);
            owner_d        = OWNER_DATA;
            if (sel_in_win) begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end
        end
        err_d = (owner_d != OWNER_NONE) && !sel_in_win;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWNER_NONE;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Error responses do not wait on the SRAM; in-window ones follow mem_rvalid_i.
    always_comb begin
        bus.instr_rvalid_o = 1'b0;
        bus.instr_err_o    = 1'b0;
        bus.instr_rdata_o  = '0;
        bus.data_rvalid_o  = 1'b0;
        bus.data_err_o     = 1'b0;
        bus.data_rdata_o   = '0;
        if (err_q || bus.mem_rvalid_i) begin
            if (owner_q == OWNER_INSTR) begin
                bus.instr_rvalid_o = 1'b1;
                bus.instr_err_o    = err_q;
                bus.instr_rdata_o  = err_q ? '0 : bus.mem_rdata_i;
            end else if (owner_q == OWNER_DATA) begin
                bus.data_rvalid_o = 1'b1;
                bus.data_err_o    = err_q;
                bus.data_rdata_o  = err_q ? '0 : bus.mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_host_arbiter.sv
// Directed self-checking bench for sram_host_arbiter; SRAM modelled as one-cycle rvalid echo.
module tb_sram_host_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    sram_host_arbiter_if bus ();

    sram_host_arbiter #(
        .MemStart   (32'h0000_0000),
        .MemSize    (65536),
        .StarveLimit(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) bus.mem_rvalid_i <= 1'b0;
        else       bus.mem_rvalid_i <= bus.mem_req_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_hosts();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
    endtask

    task automatic drive_instr(input logic [31:0] addr);
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = addr;
    endtask

    task automatic drive_data(input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_addr_i  = addr;
        bus.data_wdata_i = wdata;
    endtask

    logic [5:0] exp_gi;
    logic       prev_gi;

    initial begin
        idle_hosts();
        bus.mem_rdata_i = 32'h5555_AAAA;
`ifdef ARB_ROUND_ROBIN_EN
        exp_gi = 6'b010101;
`else
        exp_gi = 6'b101111;
`endif

        // Reset: a pending instr request must not leak through
        drive_instr(32'h80);
        @(negedge clk_i); #1;
        chk("rst_instr_gnt",    bus.instr_gnt_o,    0);
        chk("rst_mem_req",      bus.mem_req_o,      0);
        chk("rst_mem_addr",     bus.mem_addr_o,     0);
        chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("rst_data_rvalid",  bus.data_rvalid_o,  0);
        chk("rst_instr_rdata",  bus.instr_rdata_o,  0);

        // Instr read at 0x80
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("ird_gnt",      bus.instr_gnt_o, 1);
        chk("ird_data_gnt", bus.data_gnt_o,  0);
        chk("ird_mem_req",  bus.mem_req_o,   1);
        chk("ird_mem_addr", bus.mem_addr_o,  32'h80);
        chk("ird_mem_be",   bus.mem_be_o,    32'hF);
        chk("ird_mem_we",   bus.mem_we_o,    0);
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        idle_hosts();
        #1;
        chk("ird_rvalid",      bus.instr_rvalid_o, 1);
        chk("ird_rdata",       bus.instr_rdata_o,  32'hDEAD_BEEF);
        chk("ird_err",         bus.instr_err_o,    0);
        chk("ird_data_rvalid", bus.data_rvalid_o,  0);
        chk("ird_data_rdata",  bus.data_rdata_o,   0);
        chk("idle_mem_req",    bus.mem_req_o,      0);
        chk("idle_mem_addr",   bus.mem_addr_o,     0);

        // Data partial write at 0x100
        @(negedge clk_i);
        drive_data(1'b1, 4'b0011, 32'h100, 32'h1234_5678);
        #1;
        chk("dwr_gnt",       bus.data_gnt_o,  1);
        chk("dwr_instr_gnt", bus.instr_gnt_o, 0);
        chk("dwr_mem_req",   bus.mem_req_o,   1);
        chk("dwr_mem_we",    bus.mem_we_o,    1);
        chk("dwr_mem_be",    bus.mem_be_o,    32'h3);
        chk("dwr_mem_addr",  bus.mem_addr_o,  32'h100);
        chk("dwr_mem_wdata", bus.mem_wdata_o, 32'h1234_5678);
        @(negedge clk_i);
        idle_hosts();
        #1;
        chk("dwr_rvalid",       bus.data_rvalid_o,  1);
        chk("dwr_err",          bus.data_err_o,     0);
        chk("dwr_instr_rvalid", bus.instr_rvalid_o, 0);

        // Data read outside the 64 kB window
        @(negedge clk_i);
        drive_data(1'b0, 4'hF, 32'h0001_0000, 32'h0);
        #1;
        chk("oow_gnt",     bus.data_gnt_o, 1);
        chk("oow_mem_req", bus.mem_req_o,  0);
        bus.mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        idle_hosts();
        #1;
        chk("oow_rvalid",       bus.data_rvalid_o,  1);
        chk("oow_err",          bus.data_err_o,     1);
        chk("oow_rdata",        bus.data_rdata_o,   0);
        chk("oow_instr_rvalid", bus.instr_rvalid_o, 0);

        // Continuous contention
        prev_gi = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            drive_instr(32'h200);
            drive_data(1'b0, 4'hF, 32'h300, 32'h0);
            bus.mem_rdata_i = 32'hA000_0000 + 32'(c);
            #1;
            chk($sformatf("cont%0d_instr_gnt", c), bus.instr_gnt_o, 32'(exp_gi[c]));
            chk($sformatf("cont%0d_data_gnt", c),  bus.data_gnt_o,  32'(!exp_gi[c]));
            if (c > 0) begin
                chk($sformatf("cont%0d_instr_rvalid", c), bus.instr_rvalid_o, 32'(prev_gi));
                chk($sformatf("cont%0d_data_rvalid", c),  bus.data_rvalid_o,  32'(!prev_gi));
                chk($sformatf("cont%0d_rdata", c),
                    prev_gi ? bus.instr_rdata_o : bus.data_rdata_o, 32'hA000_0000 + 32'(c));
            end
            prev_gi = exp_gi[c];
        end
        @(negedge clk_i);
        idle_hosts();
        #1;
        chk("cont_last_instr_rvalid", bus.instr_rvalid_o, 32'(prev_gi));
        chk("cont_last_data_rvalid",  bus.data_rvalid_o,  32'(!prev_gi));

        // Back-to-back instr, data, instr
        @(negedge clk_i);
        drive_instr(32'h10);
        #1;
        chk("b2b_a_instr_gnt", bus.instr_gnt_o, 1);
        @(negedge clk_i);
        idle_hosts();
        drive_data(1'b0, 4'hF, 32'h20, 32'h0);
        bus.mem_rdata_i = 32'h1111_1111;
        #1;
        chk("b2b_b_data_gnt",     bus.data_gnt_o,     1);
        chk("b2b_b_instr_rvalid", bus.instr_rvalid_o, 1);
        chk("b2b_b_instr_rdata",  bus.instr_rdata_o,  32'h1111_1111);
        chk("b2b_b_data_rvalid",  bus.data_rvalid_o,  0);
        @(negedge clk_i);
        idle_hosts();
        drive_instr(32'h30);
        bus.mem_rdata_i = 32'h2222_2222;
        #1;
        chk("b2b_c_instr_gnt",    bus.instr_gnt_o,    1);
        chk("b2b_c_data_rvalid",  bus.data_rvalid_o,  1);
        chk("b2b_c_data_rdata",   bus.data_rdata_o,   32'h2222_2222);
        chk("b2b_c_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("b2b_c_instr_rdata",  bus.instr_rdata_o,  0);
        @(negedge clk_i);
        idle_hosts();
        bus.mem_rdata_i = 32'h3333_3333;
        #1;
        chk("b2b_d_instr_rvalid", bus.instr_rvalid_o, 1);
        chk("b2b_d_instr_rdata",  bus.instr_rdata_o,  32'h3333_3333);
        chk("b2b_d_data_rvalid",  bus.data_rvalid_o,  0);

        // Reset hits a granted access before its response
        @(negedge clk_i);
        drive_instr(32'h40);
        #1;
        chk("rmid_gnt", bus.instr_gnt_o, 1);
        #2;
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        chk("rmid_rst_rvalid",  bus.instr_rvalid_o, 0);
        chk("rmid_rst_gnt",     bus.instr_gnt_o,    0);
        chk("rmid_rst_mem_req", bus.mem_req_o,      0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_hosts();
        #1;
        chk("rmid_post_rvalid", bus.instr_rvalid_o, 0);
        @(negedge clk_i); #1;
        chk("rmid_post2_rvalid",      bus.instr_rvalid_o, 0);
        chk("rmid_post2_data_rvalid", bus.data_rvalid_o,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
